// File: rtl/mant_align.sv
// rtl/mant_align.sv - pipelined log-depth right-shift mantissa aligner with sticky
//
// Purpose:
//   Right-shifts an unsigned mantissa by an exponent-difference amount
//   through S = clog2(N) registered stages. Stage k conditionally shifts
//   by 2^(S-1-k). The optional sticky output is the OR of every bit shifted
//   out. Each stage has its own valid bit, so a stalled output lets upstream
//   bubbles collapse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready is combinational from out_ready)
//   in_data [N]           mantissa to align
//   in_shamt [E_W]        unsigned right-shift amount
//   in_sign               sign, carried alongside the beat unchanged
//   out_valid/out_ready   output handshake
//   out_data [N]          in_data >> in_shamt, zero-filled
//   out_sticky            OR of the shifted-out bits (0 when the sticky build is off)
//   out_sign              in_sign of the same beat
//
// Build option:
//   MANT_ALIGN_STICKY_EN  when defined, sticky logic and registers are built;
//                         otherwise out_sticky is tied to 0.
module mant_align #(
  parameter int N   = 32,
  parameter int E_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic [E_W-1:0] in_shamt,
  input  logic           in_sign,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           out_sticky,
  output logic           out_sign
);
  localparam int S = $clog2(N);

  logic [S-1:0]   v_q;
  logic [S-1:0]   adv;
  logic [S-1:0]   sh_en;
  logic           sat0;

  logic [N-1:0]   data_q   [S];
  logic [N-1:0]   data_d   [S];
  logic           sign_q   [S];
  // The last stage never consumes a shift amount, so it carries none.
  logic [E_W-1:0] shamt_q  [S-1];

  logic [N-1:0]   src_data  [S];
  logic [E_W-1:0] src_shamt [S];
  logic           src_sign  [S];
  logic [S-1:0]   src_valid;

  // A stage may load when it, or any stage after it, is empty, or when the
  // output is being taken. Bits below k are forced to 1 so only stages k..S-1
  // take part in the all-full test.
  always_comb begin
    for (int k = 0; k < S; k++) begin
      adv[k] = out_ready | ~&(v_q | S'((1 << k) - 1));
    end
  end

  assign in_ready = adv[0];

  // Stage k is fed by the module inputs (k = 0) or by stage k-1.
  always_comb begin
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_sign[0]  = in_sign;
    src_valid[0] = in_valid;
    for (int k = 1; k < S; k++) begin
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_sign[k]  = sign_q[k-1];
      src_valid[k] = v_q[k-1];
    end
  end

  // Any shamt bit at or above position S means the shift is >= N.
  assign sat0 = |(in_shamt >> S);

  always_comb begin
    for (int k = 0; k < S; k++) begin
      sh_en[k] = |(src_shamt[k] & (E_W'(1) << (S - 1 - k)));
    end
  end

  always_comb begin
    for (int k = 0; k < S; k++) begin
      if ((k == 0) && sat0) begin
        data_d[k] = '0;
      end else if (sh_en[k]) begin
        data_d[k] = src_data[k] >> (1 << (S - 1 - k));
      end else begin
        data_d[k] = src_data[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < S; k++) begin
        data_q[k] <= '0;
        sign_q[k] <= 1'b0;
      end
      for (int k = 0; k < S - 1; k++) begin
        shamt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (adv[k]) begin
          v_q[k]    <= src_valid[k];
          data_q[k] <= data_d[k];
          sign_q[k] <= src_sign[k];
        end
      end
      for (int k = 0; k < S - 1; k++) begin
        if (adv[k]) begin
          shamt_q[k] <= src_shamt[k];
        end
      end
    end
  end

`ifdef MANT_ALIGN_STICKY_EN
  logic sticky_q   [S];
  logic sticky_d   [S];
  logic src_sticky [S];

  // Dropped bits of stage k are the low 2^(S-1-k) bits of its input.
  always_comb begin
    src_sticky[0] = 1'b0;
    for (int k = 1; k < S; k++) begin
      src_sticky[k] = sticky_q[k-1];
    end
    for (int k = 0; k < S; k++) begin
      if ((k == 0) && sat0) begin
        sticky_d[k] = |in_data;
      end else begin
        sticky_d[k] = src_sticky[k] |
                      (sh_en[k] & (|(src_data[k] & ~({N{1'b1}} << (1 << (S - 1 - k))))));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) begin
        sticky_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (adv[k]) begin
          sticky_q[k] <= sticky_d[k];
        end
      end
    end
  end

  assign out_sticky = sticky_q[S-1];
`else
  assign out_sticky = 1'b0;
`endif

  assign out_valid = v_q[S-1];
  assign out_data  = data_q[S-1];
  assign out_sign  = sign_q[S-1];

endmodule

// File: tb/tb_mant_align.sv
// tb/tb_mant_align.sv - self-checking directed and randomised bench for mant_align
module tb_mant_align;
  localparam int N   = 32;
  localparam int E_W = 6;
  localparam int S   = 5;
`ifdef MANT_ALIGN_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        st;
    logic        sg;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic [E_W-1:0] in_shamt;
  logic           in_sign;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic           out_sticky;
  logic           out_sign;

  int n_checks = 0;
  int n_fail   = 0;

  mant_align #(.N(N), .E_W(E_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sticky(out_sticky),
    .out_sign  (out_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain shift with sticky = OR of the bits below the shift point.
  function automatic logic [32:0] model(input logic [31:0] d, input logic [5:0] sh);
    logic [63:0] m;
    logic [31:0] r;
    logic        st;
    if (sh >= 6'd32) begin
      r  = '0;
      st = |d;
    end else begin
      r  = d >> sh;
      m  = (64'd1 << sh) - 64'd1;
      st = |({32'd0, d} & m);
    end
    return {st & STK, r};
  endfunction

  // Drives one beat into an empty pipe with out_ready high and returns the
  // first output beat plus the number of clock edges it took.
  task automatic send_one(input logic [31:0] d, input logic [5:0] sh, input logic sg,
                          output logic [31:0] od, output logic ost, output logic osg,
                          output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_sign = sg; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    od = out_data; ost = out_sticky; osg = out_sign;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_sign = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    n_checks++; if (out_sticky !== 1'b0 || out_sign !== 1'b0) begin
      n_fail++; $display("FAIL reset_sticky_sign: got %b%b expected 00", out_sticky, out_sign);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] od; logic ost, osg; int lat;
    send_one(32'h8000_0000, 6'd4, 1'b0, od, ost, osg, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    n_checks++; if (od !== 32'h0800_0000) begin n_fail++; $display("FAIL basic_data: got %h expected 08000000", od); end
    n_checks++; if (ost !== 1'b0) begin n_fail++; $display("FAIL basic_sticky: got %b expected 0", ost); end
    @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_cycle: got %b expected 0", out_valid); end
  endtask

  task automatic test_sticky();
    logic [31:0] od; logic ost, osg; int lat;
    send_one(32'h0000_001F, 6'd3, 1'b1, od, ost, osg, lat);
    n_checks++; if (od !== 32'h0000_0003) begin n_fail++; $display("FAIL sticky_data: got %h expected 00000003", od); end
    n_checks++; if (ost !== STK) begin n_fail++; $display("FAIL sticky_bit: got %b expected %b", ost, STK); end
    n_checks++; if (osg !== 1'b1) begin n_fail++; $display("FAIL sticky_sign: got %b expected 1", osg); end
  endtask

  task automatic test_boundaries();
    logic [31:0] td [8] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h8000_0001, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [5:0]  ts [8] = '{6'd32, 6'd63, 6'd32, 6'd63, 6'd0, 6'd31, 6'd31, 6'd16};
    logic [31:0] ed [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h1, 32'h1, 32'h1234};
    logic        es [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] od; logic ost, osg; int lat;
    for (int i = 0; i < 8; i++) begin
      send_one(td[i], ts[i], i[0], od, ost, osg, lat);
      n_checks++; if (od !== ed[i] || osg !== i[0]) begin
        n_fail++; $display("FAIL boundary_data[%0d]: got %h/%b expected %h/%b", i, od, osg, ed[i], i[0]);
      end
      n_checks++; if (ost !== (es[i] & STK)) begin
        n_fail++; $display("FAIL boundary_sticky[%0d]: got %b expected %b", i, ost, es[i] & STK);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed [8] = '{32'h8000_00FF, 32'h4000_007F, 32'h2000_003F, 32'h1000_001F,
                            32'h0800_000F, 32'h0400_0007, 32'h0200_0003, 32'h0100_0001};
    logic [3:0]  pat = 4'b1001;
    int sent = 0, recv = 0, cyc = 0;
    logic saw_full = 1'b0, stall_prev = 1'b0, exp_ir;
    logic [31:0] hold_d; logic hold_s, hold_g;
    @(negedge clk);
    while (recv < 8 && cyc < 200) begin
      out_ready = pat[cyc % 4];
      if (sent < 8) begin
        in_valid = 1'b1; in_data = 32'h8000_00FF; in_shamt = 6'(sent); in_sign = sent[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_prev) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== hold_d || out_sticky !== hold_s || out_sign !== hold_g) begin
          n_fail++; $display("FAIL b2b_stall_stable: got %b/%h/%b/%b expected 1/%h/%b/%b",
                             out_valid, out_data, out_sticky, out_sign, hold_d, hold_s, hold_g);
        end
      end
      exp_ir = !((sent - recv) == S && !out_ready);
      n_checks++; if (in_ready !== exp_ir) begin
        n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ir);
      end
      if (in_ready === 1'b0) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        n_checks++; if (out_data !== ed[recv] || out_sticky !== (STK & (recv != 0)) || out_sign !== recv[0]) begin
          n_fail++; $display("FAIL b2b_beat[%0d]: got %h/%b/%b expected %h/%b/%b", recv,
                             out_data, out_sticky, out_sign, ed[recv], STK & (recv != 0), recv[0]);
        end
        recv++;
      end
      stall_prev = out_valid && !out_ready;
      hold_d = out_data; hold_s = out_sticky; hold_g = out_sign;
      if (in_valid && in_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (recv !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", recv); end
    n_checks++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL b2b_backpressure: got %b expected 1", saw_full); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] od; logic ost, osg; int lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1111_0000 << i; in_shamt = 6'd0; in_sign = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_precond: got %b expected 1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got %b expected 0", out_valid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    send_one(32'h0000_F000, 6'd12, 1'b1, od, ost, osg, lat);
    n_checks++; if (lat !== 5 || od !== 32'h0000_000F || ost !== 1'b0 || osg !== 1'b1) begin
      n_fail++; $display("FAIL midreset_new_beat: got lat %0d %h/%b/%b expected lat 5 0000000f/0/1", lat, od, ost, osg);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [32:0] r;
    int sent = 0, recv = 0, cyc = 0;
    @(negedge clk);
    while (recv < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 1000) begin
        in_valid = ($urandom_range(0, 4) != 0);
        case ($urandom_range(0, 3))
          0:       in_data = $urandom;
          1:       in_data = 32'h1 << $urandom_range(0, 31);
          2:       in_data = 32'h0;
          default: in_data = $urandom & 32'hFF;
        endcase
        in_shamt = 6'($urandom_range(0, 63));
        in_sign  = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_unexpected_beat: got %h with empty scoreboard", out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== e.d || out_sticky !== e.st || out_sign !== e.sg) begin
            n_fail++; $display("FAIL rand_beat[%0d]: got %h/%b/%b expected %h/%b/%b", recv,
                               out_data, out_sticky, out_sign, e.d, e.st, e.sg);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        r = model(in_data, in_shamt);
        q.push_back({r[31:0], r[32], in_sign});
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (recv !== 1000 || q.size() != 0) begin
      n_fail++; $display("FAIL rand_count: got %0d beats, %0d pending expected 1000, 0", recv, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sticky();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
